// File: rtl/demux_1x2_if.sv
// demux_1x2_if: serialized input stream and paired lane outputs of the 1:2 receive splitter
interface demux_1x2_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out0;
  logic             valid_out1;
  logic             orphan;
  modport master (output data_in, valid_in, input data_out0, data_out1, valid_out0, valid_out1, orphan);
  modport slave (input data_in, valid_in, output data_out0, data_out1, valid_out0, valid_out1, orphan);
endinterface

// File: rtl/demux_1x2.sv
// demux_1x2: steers consecutive valid words alternately to lane 0 and lane 1 as held, coherent pairs
module demux_1x2 #(
  parameter int WIDTH = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int HOLD_CYCLES = 2
) (
  input logic clk_2f,
  input logic reset,
  demux_1x2_if.slave bus
);
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [IW-1:0] FLUSH_MAX = IW'(FLUSH_CYCLES);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYCLES);
  typedef enum logic {IDLE, HALF} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] stage, stage_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [HW-1:0] hold_cnt;
  logic pair, flush;
  // next state: stage a lane-0 word, then pair it with the next valid word or flush it after enough idle cycles
  always_comb begin
    state_n = state;
    stage_n = stage;
    idle_n = idle_cnt;
    pair = 1'b0;
    flush = 1'b0;
    if (state == IDLE) begin
      if (bus.valid_in) begin
        stage_n = bus.data_in;
        idle_n = '0;
        state_n = HALF;
      end
    end else if (bus.valid_in) begin
      pair = 1'b1;
      state_n = IDLE;
    end else if (idle_cnt + IW'(1) == FLUSH_MAX) begin
      flush = 1'b1;
      state_n = IDLE;
    end else begin
      idle_n = (idle_cnt == FLUSH_MAX) ? idle_cnt : idle_cnt + IW'(1);
    end
  end
  // registers: FSM state, emitted lane words, and the hold counter that times out the output valids
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state <= IDLE;
      stage <= '0;
      idle_cnt <= '0;
      hold_cnt <= '0;
      bus.data_out0 <= '0;
      bus.data_out1 <= '0;
      bus.valid_out0 <= 1'b0;
      bus.valid_out1 <= 1'b0;
      bus.orphan <= 1'b0;
    end else begin
      state <= state_n;
      stage <= stage_n;
      idle_cnt <= idle_n;
      bus.orphan <= flush;
      if (pair || flush) begin
        bus.data_out0 <= stage;
        if (pair) bus.data_out1 <= bus.data_in;
        bus.valid_out0 <= 1'b1;
        bus.valid_out1 <= pair;
        hold_cnt <= HOLD_LD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) begin
          bus.valid_out0 <= 1'b0;
          bus.valid_out1 <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/demux_1x2.md
# demux_1x2

Receive-side 1:2 lane splitter for the PHY receive path. Takes the single serialized byte stream at the double-rate clock and steers consecutive valid words alternately to lane 0 and lane 1. Both lane outputs are presented together as a coherent pair, held long enough for a half-rate consumer to sample them. It is the counterpart of the transmit-side 2:1 interleaver: words merged as lane0, lane1, lane0, lane1 come back out on their original lanes.

## Interface
- WIDTH, 8, data word width
- FLUSH_CYCLES, 2, consecutive invalid input cycles after which an unpaired lane-0 word is emitted alone (≥1)
- HOLD_CYCLES, 2, cycles the output valids stay high after each emission (≥1)

- clk_2f  input  1  double-rate clock; all logic on rising edge
- reset  input  1  synchronous, active-high; dominates all other inputs on the same edge
- data_in  input  WIDTH  serialized input word
- valid_in  input  1  data_in qualifier, sampled every edge
- data_out0  output  WIDTH  lane-0 word; reset 0
- data_out1  output  WIDTH  lane-1 word; reset 0
- valid_out0  output  1  lane-0 qualifier; reset 0
- valid_out1  output  1  lane-1 qualifier; reset 0
- orphan  output  1  one-cycle pulse when a lane-0 word is flushed without a partner; reset 0

## Operation
- State machine, two states:
  - IDLE: no staged word. valid_in=1 → capture data_in into stage register, idle counter ← 0, go HALF. valid_in=0 → stay.
  - HALF: lane-0 word staged. valid_in=1 → pair emit: data_out0 ← stage, data_out1 ← data_in, valid_out0=valid_out1=1, hold counter ← HOLD_CYCLES, go IDLE. valid_in=0 → idle counter +1; when the increment reaches FLUSH_CYCLES → flush emit: data_out0 ← stage, valid_out0=1, valid_out1=0, data_out1 unchanged, orphan=1 for that cycle, hold counter ← HOLD_CYCLES, go IDLE.
- Lane assignment is strictly by arrival order of valid words. Invalid cycles do not advance lane selection. The first valid word after reset or after any emission is always lane 0.
- Hold counter: decrements each cycle while nonzero. When it goes from 1 to 0, both valid_outs drop to 0. data_out0/1 keep their last values and are never cleared except by reset.
- A new emission while the hold counter is nonzero reloads it and overwrites the outputs. With HOLD_CYCLES=2 and back-to-back pairs, the valids stay continuously high.
- Idle counter is sized for FLUSH_CYCLES, saturates, and is used only in HALF.
- Reset: stage discarded, state IDLE, all counters 0, all outputs 0.

## Timing
- Word A is sampled at edge k and word B at edge k+1. Pair outputs are visible after edge k+1, one edge of latency from the second word.
- valid_out0/1 are high after edges k+1 … k+HOLD_CYCLES and low after edge k+1+HOLD_CYCLES, unless reloaded.
- Flush: word A at edge k, valid_in=0 at edges k+1 … k+FLUSH_CYCLES. Outputs update at edge k+FLUSH_CYCLES, and orphan is high only in the following cycle.
- If valid_in returns to 1 at edge k+j, with j ≤ FLUSH_CYCLES and all earlier cycles invalid, that word pairs with A. No flush occurs.
- Continuous valid stream A,B,C,D,… yields pairs (A,B), (C,D), … every 2 cycles.
- reset asserted at any edge clears the block at that edge regardless of valid_in. The first valid sample after reset deasserts is lane 0.

## Test plan
- Reset check: hold reset 3 cycles with valid_in=1, data_in=0xFF → all outputs 0, orphan 0; first word after release staged as lane 0.
- Pair: 0x11 then 0x22 on consecutive edges → after second edge data_out0=0x11, data_out1=0x22, both valids high 2 cycles, then low with data held.
- Stream: 0xA0,0xA1,0xA2,0xA3 back-to-back → (0xA0,0xA1) then (0xA2,0xA3); valid_out0/1 continuously high 4 cycles; orphan never asserts.
- Gapped pair: 0x33, one invalid cycle, 0x44 → data_out0=0x33, data_out1=0x44, orphan stays 0.
- Flush: 0x55, then valid_in=0 for 2 cycles → data_out0=0x55, valid_out0=1, valid_out1=0, orphan one-cycle pulse; next valid word 0x66 lands on lane 0.
- Reset mid-operation: stage 0x77, assert reset next edge, release, send 0x88,0x99 → pair (0x88,0x99); 0x77 never appears.
